// File: rtl/memoria_img_pkg.sv
`default_nettype none
// ============================================================================
// memoria_img_pkg : shared constants, scan FSM states and read latency.
// MEMORIA_IMG_OUTREG_EN selects the registered memory output (READ_LAT = 2).
// Revision: 1.0
// ============================================================================
package memoria_img_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DEPTH  = 81920;

`ifdef MEMORIA_IMG_OUTREG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/memoria_img_fifo2.sv
`default_nettype none
// ============================================================================
// memoria_img_fifo2 : two-entry valid/ready FIFO for the pixel stream.
// Revision: 1.0
// ============================================================================
module memoria_img_fifo2 #(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = slot[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= in_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/memoria_img_stream.sv
`default_nettype none
// ============================================================================
// memoria_img_stream : single-port image memory, Avalon-MM slave plus an
// Avalon-ST frame scanner. Define MEMORIA_IMG_OUTREG_EN for a registered output.
// Revision: 1.0
// ============================================================================
module memoria_img_stream
    import memoria_img_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter     INIT_FILE = "imagem.mif"
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    input  logic              st_start,
    input  logic [ADDR_W-1:0] st_base,
    input  logic [ADDR_W:0]   st_len,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    output logic              st_sop,
    output logic              st_eop,
    input  logic              st_ready,
    output logic              busy,
    output logic              done
);

    scan_state_t         state, next_state;
    logic                mm_wr, mm_rd, mm_any;
    logic                mem_we, mem_re;
    logic                fetch_go, last_idx, pop, push, fifo_in_ready;
    logic [ADDR_W-1:0]   raddr, fetch_addr, start_addr;
    logic [ADDR_W:0]     idx, len;
    logic [DATA_W-1:0]   rd_q, mem_dout;
    logic [READ_LAT-1:0] mm_v, mm_oob, f_v, f_sop, f_eop;
    logic [1:0]          infl, fifo_count;
    logic [2:0]          occ;
    logic [DATA_W+1:0]   fifo_out;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
    endfunction

    assign mm_wr  = s1_chipselect && s1_write;
    assign mm_rd  = s1_chipselect && s1_read && !s1_write;
    assign mm_any = mm_wr || mm_rd;
    assign mem_we = mm_wr && in_range(s1_address);
    assign mem_re = mm_rd || fetch_go;
    assign raddr  = mm_rd ? s1_address : fetch_addr;

    assign start_addr = in_range(st_base) ? st_base : ADDR_W'(st_base - ADDR_W'(DEPTH));
    assign last_idx   = (idx == len - (ADDR_W+1)'(1));

    // Credit check counts the word leaving the FIFO this cycle so a full-rate
    // stream keeps flowing without ever overrunning the two entries.
    always_comb begin
        infl = 2'd0;
        for (int i = 0; i < READ_LAT; i++) begin
            infl = infl + 2'(f_v[i]);
        end
    end
    assign pop      = st_valid && st_ready;
    assign occ      = 3'(fifo_count) + 3'(infl) - 3'(pop);
    assign fetch_go = (state == RUN) && !mm_any && (occ < 3'd2);

    if (INIT_FILE != "") begin : g_init_mem
        (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (mem_we) mem[s1_address] <= s1_writedata;
            if (mem_re) rd_q <= mem[raddr];
        end
    end else begin : g_plain_mem
        logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (mem_we) mem[s1_address] <= s1_writedata;
            if (mem_re) rd_q <= mem[raddr];
        end
    end

`ifdef MEMORIA_IMG_OUTREG_EN
    logic [DATA_W-1:0] rd_q2;
    always_ff @(posedge clk) rd_q2 <= rd_q;
    assign mem_dout = rd_q2;
`else
    assign mem_dout = rd_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_v   <= '0;
            mm_oob <= '0;
            f_v    <= '0;
            f_sop  <= '0;
            f_eop  <= '0;
        end else begin
            mm_v[0]   <= mm_rd;
            mm_oob[0] <= !in_range(s1_address);
            f_v[0]    <= fetch_go;
            f_sop[0]  <= (idx == '0);
            f_eop[0]  <= last_idx;
            for (int i = 1; i < READ_LAT; i++) begin
                mm_v[i]   <= mm_v[i-1];
                mm_oob[i] <= mm_oob[i-1];
                f_v[i]    <= f_v[i-1];
                f_sop[i]  <= f_sop[i-1];
                f_eop[i]  <= f_eop[i-1];
            end
        end
    end

    assign s1_readdatavalid = mm_v[READ_LAT-1];
    assign s1_readdata      = (mm_v[READ_LAT-1] && !mm_oob[READ_LAT-1]) ? mem_dout : '0;
    assign push             = f_v[READ_LAT-1] && fifo_in_ready;

    memoria_img_fifo2 #(
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   ({f_sop[READ_LAT-1], f_eop[READ_LAT-1], mem_dout}),
        .out_valid (st_valid),
        .out_ready (st_ready),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign st_sop  = fifo_out[DATA_W+1];
    assign st_eop  = fifo_out[DATA_W];
    assign st_data = fifo_out[DATA_W-1:0];

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (st_start && st_len != '0) next_state = RUN;
            RUN:     if (fetch_go && last_idx)     next_state = DRAIN;
            DRAIN:   if (pop && st_eop)            next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            len        <= '0;
            fetch_addr <= '0;
            done       <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state == IDLE && st_start && st_len == '0) ||
                     (state == DRAIN && next_state == IDLE);
            if (state == IDLE && st_start && st_len != '0) begin
                idx        <= '0;
                len        <= st_len;
                fetch_addr <= start_addr;
            end else if (fetch_go) begin
                idx        <= idx + (ADDR_W+1)'(1);
                fetch_addr <= (fetch_addr == ADDR_W'(DEPTH - 1)) ? '0 : fetch_addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
